udp_ev_timestamper: RTL and testbench
=====================================

UDP_EV_TIMESTAMPER -- requirements
Module: udp_ev_timestamper

Interface
REQ-001 The block SHALL have the following parameters:
- ID_W, 16, event ID width.
- TS_W, 64, timestamp width.
- DEPTH, 8, pending-table entries; power of 2, range 2..32.
- RES_DEPTH, 4, result FIFO entries; power of 2.

REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  start-event strobe, one event per cycle
- start_id  in  ID_W  start-event ID
- end_valid  in  1  end-event strobe, one event per cycle
- end_id  in  ID_W  end-event ID
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_id  out  ID_W  result ID
- out_start_ts  out  TS_W  captured start timestamp
- out_end_ts  out  TS_W  captured end timestamp
- out_delta  out  TS_W  end minus start
- ts_now  out  TS_W  free-running counter value
- cnt_start_drop  out  16  starts dropped because the table was full
- cnt_end_miss  out  16  ends with no matching pending start
- cnt_res_drop  out  16  results dropped because the FIFO was full

Function
REQ-003 ts_now SHALL increment by 1 every cycle after reset and wrap from 2^TS_W-1 to 0.
REQ-004 Start and end events SHALL be stamped with the ts_now value of the cycle in which their valid is high.
REQ-005 Start event with an ID not pending SHALL allocate the lowest-index free slot: valid=1, id, start_ts.
REQ-006 Start event with an ID already pending SHALL overwrite that slot's start_ts; no new slot is allocated and no counter changes.
REQ-007 Start event with a new ID while all DEPTH slots are valid SHALL be dropped and SHALL increment cnt_start_drop.
REQ-008 End event SHALL search all valid slots combinationally for end_id.
REQ-009 On an end hit the block SHALL clear the slot and push the result {id, start_ts, end_ts, delta} into the result FIFO at the next clk edge.
REQ-010 On an end miss the block SHALL increment cnt_end_miss and push no result.
REQ-011 delta SHALL equal (end_ts - start_ts) mod 2^TS_W, which is correct across counter wrap.
REQ-012 Latency SHALL be end_valid high in cycle N -> out_valid high in cycle N+1 when the FIFO was empty.
REQ-013 The result FIFO SHALL be first-word-fall-through.
REQ-014 out_* SHALL be driven from the FIFO head, with out_valid = not empty.
REQ-015 The FIFO SHALL pop when out_valid and out_ready are both high.
REQ-016 While out_valid is high and out_ready is low, the out_* payload SHALL hold stable.
REQ-017 An end hit when the FIFO is full and not popping that cycle SHALL still free the slot, SHALL drop the result, and SHALL increment cnt_res_drop.
REQ-018 A simultaneous push and pop on a full FIFO SHALL succeed with no drop.
REQ-019 Simultaneous start and end in the same cycle SHALL both be processed, with the end looked up against the table state before that cycle's start.
- With the same ID, the end misses if the ID was not already pending, and the start then allocates.
- With the same ID already pending, the end hits the old entry and the start re-allocates.
REQ-020 A slot freed by an end SHALL NOT be allocatable by a start in the same cycle.
REQ-021 All counters SHALL saturate at 16'hFFFF.

Reset
REQ-022 rst_n low SHALL asynchronously clear:
- ts_now
- all slot valid bits
- FIFO pointers (out_valid=0)
- all three counters
REQ-023 Reset deassertion SHALL be synchronised internally with a 2-flop synchroniser, and ts_now SHALL first increment the cycle after the synchronised release.
REQ-024 Reset mid-operation SHALL discard all pending starts and queued results, and no result SHALL emerge after reset release without a new start/end pair.
REQ-025 Event strobes SHALL be ignored while reset is asserted.

Structure
REQ-026 Package ts_pkg SHALL hold:
- typedef ts_result_t {id, start_ts, end_ts, delta}, parameterised through package constants ID_W and TS_W
- constant CNT_W = 16
REQ-027 The result FIFO SHALL be the sub-module ts_result_fifo: FWFT, parameters DEPTH and payload width, ports push/full/pop/empty.
REQ-028 The pending table, priority encoder and match logic SHALL reside in udp_ev_timestamper.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Basic: start id=5 at ts=10, end id=5 at ts=47, out_ready=1 -> out_valid in cycle after end, with id=5, start=10, end=47, delta=37.
- Wrap: force ts_now to 2^64-3, start id=1, end id=1 after 5 cycles -> delta=5.
- Table full: 8 starts with ids 0..7, then start id=8 -> cnt_start_drop=1; end id=8 -> cnt_end_miss=1; end id=3 -> hit, and a new start id=9 then allocates slot 3.
- Backpressure: out_ready=0, 5 matched pairs -> 4 results queued, cnt_res_drop=1; raise out_ready -> 4 results in pairing order, payload stable while stalled.
- Simultaneous: same-cycle start id=2 and end id=2 with no prior start -> miss=1 and id 2 pending; next end id=2 -> hit with delta equal to the cycle gap.
- Reset: assert rst_n low with 3 pending starts and 2 queued results -> out_valid=0 and counters 0 immediately; after release, end ids of the old starts -> all misses.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared types and constants for the UDP event timestamper.
package ts_pkg;

  localparam int ID_W  = 16;
  localparam int TS_W  = 64;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] start_ts;
    logic [TS_W-1:0] end_ts;
    logic [TS_W-1:0] delta;
  } ts_result_t;

endpackage

// File: rtl/ts_result_fifo.sv
// First-word-fall-through result FIFO; a push on a full FIFO succeeds only when a pop happens in the same cycle.
module ts_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/udp_ev_timestamper.sv
// Pairs start/end events by ID, timestamps both against a free-running counter
// and queues {id, start, end, delta} results for a ready/valid consumer.
module udp_ev_timestamper
  import ts_pkg::*;
#(
  parameter int ID_W      = 16,
  parameter int TS_W      = 64,
  parameter int DEPTH     = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  input  logic [ID_W-1:0]  start_id,
  input  logic             end_valid,
  input  logic [ID_W-1:0]  end_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [TS_W-1:0]  out_start_ts,
  output logic [TS_W-1:0]  out_end_ts,
  output logic [TS_W-1:0]  out_delta,
  output logic [TS_W-1:0]  ts_now,
  output logic [CNT_W-1:0] cnt_start_drop,
  output logic [CNT_W-1:0] cnt_end_miss,
  output logic [CNT_W-1:0] cnt_res_drop
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int RES_W = ID_W + 3*TS_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] first_set(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Reset asserts asynchronously, releases two clocks after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) ts_q <= '0;
    else            ts_q <= ts_q + TS_W'(1);
  end

  assign ts_now = ts_q;

  logic [DEPTH-1:0] slot_vld;
  logic [ID_W-1:0]  slot_id [DEPTH];
  logic [TS_W-1:0]  slot_ts [DEPTH];

  logic [DEPTH-1:0] end_match;
  logic [DEPTH-1:0] start_match;
  logic [DEPTH-1:0] start_keep;
  logic [IDX_W-1:0] end_idx;
  logic [IDX_W-1:0] ovr_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             end_hit;
  logic             end_miss;
  logic             start_ovr;
  logic             start_new;
  logic             start_alloc;
  logic             start_drop;

  always_comb begin
    end_match   = '0;
    start_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      end_match[i]   = slot_vld[i] && (slot_id[i] == end_id);
      start_match[i] = slot_vld[i] && (slot_id[i] == start_id);
    end
  end

  // A slot the end is clearing this cycle is neither overwritten nor reallocated.
  assign start_keep  = start_match & ~({DEPTH{end_valid}} & end_match);
  assign end_hit     = end_valid && (|end_match);
  assign end_miss    = end_valid && !(|end_match);
  assign start_ovr   = start_valid && (|start_keep);
  assign start_new   = start_valid && !start_ovr;
  assign start_alloc = start_new && !(&slot_vld);
  assign start_drop  = start_new && (&slot_vld);
  assign end_idx     = first_set(end_match);
  assign ovr_idx     = first_set(start_keep);
  assign alloc_idx   = first_set(~slot_vld);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      slot_vld <= '0;
    end else begin
      if (end_hit)     slot_vld[end_idx]   <= 1'b0;
      if (start_alloc) slot_vld[alloc_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_alloc) begin
      slot_id[alloc_idx] <= start_id;
      slot_ts[alloc_idx] <= ts_q;
    end
    if (start_ovr) slot_ts[ovr_idx] <= ts_q;
  end

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             res_drop;
  logic [TS_W-1:0]  hit_start_ts;
  logic [RES_W-1:0] res_din;
  logic [RES_W-1:0] res_dout;

  assign hit_start_ts = slot_ts[end_idx];
  assign res_din      = {slot_id[end_idx], hit_start_ts, ts_q, ts_q - hit_start_ts};
  assign fifo_pop     = out_valid && out_ready;
  assign res_drop     = end_hit && fifo_full && !fifo_pop;

  ts_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (RES_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n_int),
    .push      (end_hit),
    .push_data (res_din),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .pop_data  (res_dout)
  );

  assign out_valid = !fifo_empty;
  assign {out_id, out_start_ts, out_end_ts, out_delta} = res_dout;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt_start_drop <= '0;
      cnt_end_miss   <= '0;
      cnt_res_drop   <= '0;
    end else begin
      if (start_drop) cnt_start_drop <= sat_inc(cnt_start_drop);
      if (end_miss)   cnt_end_miss   <= sat_inc(cnt_end_miss);
      if (res_drop)   cnt_res_drop   <= sat_inc(cnt_res_drop);
    end
  end

endmodule

// File: tb/tb_udp_ev_timestamper.sv
// Scoreboard bench: a slot-table/queue reference model pushes expected results, a monitor compares the FIFO head.
module tb_udp_ev_timestamper;
  import ts_pkg::*;

  localparam int DEPTH     = 8;
  localparam int RES_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic [ID_W-1:0]  start_id = '0;
  logic             end_valid = 1'b0;
  logic [ID_W-1:0]  end_id = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [ID_W-1:0]  out_id;
  logic [TS_W-1:0]  out_start_ts, out_end_ts, out_delta, ts_now;
  logic [CNT_W-1:0] cnt_start_drop, cnt_end_miss, cnt_res_drop;

  int checks = 0;
  int failures = 0;

  ts_result_t       exp_q[$];
  logic [TS_W-1:0]  ts_ofs = '0;
  logic [TS_W-1:0]  m_cyc = '0;
  int               m_sc = 0;
  logic [CNT_W-1:0] m_sd = '0, m_em = '0, m_rd = '0;
  bit               m_vld [DEPTH];
  logic [ID_W-1:0]  m_id  [DEPTH];
  logic [TS_W-1:0]  m_st  [DEPTH];

  udp_ev_timestamper #(
    .ID_W(ID_W), .TS_W(TS_W), .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_id(start_id),
    .end_valid(end_valid), .end_id(end_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
    .ts_now(ts_now),
    .cnt_start_drop(cnt_start_drop), .cnt_end_miss(cnt_end_miss), .cnt_res_drop(cnt_res_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // One clock of event handling: end looked up first, start sees the table afterwards
  // but may only allocate a slot that was free before this cycle.
  task automatic model_edge();
    logic [TS_W-1:0] now;
    bit              pre_vld [DEPTH];
    int              hit;
    int              free;
    ts_result_t      r;
    now = m_cyc + ts_ofs;
    pre_vld = m_vld;
    if (end_valid) begin
      hit = -1;
      for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_id[i] == end_id) hit = i;
      if (hit >= 0) begin
        r.id = m_id[hit]; r.start_ts = m_st[hit]; r.end_ts = now; r.delta = now - m_st[hit];
        m_vld[hit] = 1'b0;
        if (exp_q.size() < RES_DEPTH) exp_q.push_back(r);
        else m_rd = sat(m_rd);
      end else begin
        m_em = sat(m_em);
      end
    end
    if (start_valid) begin
      hit = -1;
      for (int i = 0; i < DEPTH; i++) if (m_vld[i] && m_id[i] == start_id) hit = i;
      if (hit >= 0) begin
        m_st[hit] = now;
      end else begin
        free = -1;
        for (int i = DEPTH-1; i >= 0; i--) if (!pre_vld[i]) free = i;
        if (free >= 0) begin
          m_vld[free] = 1'b1; m_id[free] = start_id; m_st[free] = now;
        end else begin
          m_sd = sat(m_sd);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_sc = 0; m_cyc = '0; m_sd = '0; m_em = '0; m_rd = '0;
        foreach (m_vld[i]) m_vld[i] = 1'b0;
      end else if (m_sc < 2) begin
        m_sc++;
      end else begin
        model_edge();
        m_cyc = m_cyc + 64'd1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        chk("ts_now", ts_now, m_cyc + ts_ofs);
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0 && out_valid) begin
          chk("out_id", 64'(out_id), 64'(exp_q[0].id));
          chk("out_start_ts", out_start_ts, exp_q[0].start_ts);
          chk("out_end_ts", out_end_ts, exp_q[0].end_ts);
          chk("out_delta", out_delta, exp_q[0].delta);
        end
        chk("cnt_start_drop", 64'(cnt_start_drop), 64'(m_sd));
        chk("cnt_end_miss", 64'(cnt_end_miss), 64'(m_em));
        chk("cnt_res_drop", 64'(cnt_res_drop), 64'(m_rd));
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic ev(input bit s, input int sid, input bit e, input int eid);
    start_valid = s; start_id = ID_W'(sid);
    end_valid = e; end_id = ID_W'(eid);
    @(negedge clk);
    start_valid = 1'b0; end_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ts_ofs = '0; start_valid = 1'b0; end_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_ts(input logic [63:0] v);
    for (int k = 0; k < 200 && (m_cyc + ts_ofs) != v; k++) @(negedge clk);
    chk("wait_ts", m_cyc + ts_ofs, v);
  endtask

  initial begin
    logic [ID_W-1:0] hold_id;
    logic [TS_W-1:0] hold_d;
    logic [TS_W-1:0] hold_s;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ts_now", ts_now, 64'd0);
    chk("rst_cnt_start_drop", 64'(cnt_start_drop), 64'd0);
    chk("rst_cnt_end_miss", 64'(cnt_end_miss), 64'd0);
    chk("rst_cnt_res_drop", 64'(cnt_res_drop), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic pairing
    do_reset();
    wait_ts(64'd10);
    ev(1, 5, 0, 0);
    wait_ts(64'd47);
    ev(0, 0, 1, 5);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_id", 64'(out_id), 64'd5);
    chk("basic_start", out_start_ts, 64'd10);
    chk("basic_end", out_end_ts, 64'd47);
    chk("basic_delta", out_delta, 64'd37);

    // Counter wrap
    do_reset();
    force dut.ts_q = 64'hFFFF_FFFF_FFFF_FFFD;
    ts_ofs = 64'hFFFF_FFFF_FFFF_FFFD - m_cyc;
    start_valid = 1'b1; start_id = ID_W'(1);
    #1 release dut.ts_q;
    @(negedge clk);
    start_valid = 1'b0;
    idle(4);
    ev(0, 0, 1, 1);
    chk("wrap_start", out_start_ts, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("wrap_end", out_end_ts, 64'd2);
    chk("wrap_delta", out_delta, 64'd5);

    // Table full
    do_reset();
    for (int i = 0; i < 8; i++) ev(1, i, 0, 0);
    ev(1, 8, 0, 0);
    chk("full_start_drop", 64'(cnt_start_drop), 64'd1);
    ev(0, 0, 1, 8);
    chk("full_end_miss", 64'(cnt_end_miss), 64'd1);
    ev(0, 0, 1, 3);
    chk("full_hit_valid", 64'(out_valid), 64'd1);
    chk("full_hit_id", 64'(out_id), 64'd3);
    ev(1, 9, 0, 0);
    chk("full_slot3_vld", 64'(dut.slot_vld[3]), 64'd1);
    chk("full_slot3_id", 64'(dut.slot_id[3]), 64'd9);
    chk("full_start_drop2", 64'(cnt_start_drop), 64'd1);

    // Backpressure, then push+pop on a full FIFO
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) ev(1, 10 + i, 0, 0);
    for (int i = 0; i < 5; i++) ev(0, 0, 1, 10 + i);
    chk("bp_res_drop", 64'(cnt_res_drop), 64'd1);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_head_id", 64'(out_id), 64'd10);
    hold_id = out_id; hold_d = out_delta; hold_s = out_start_ts;
    idle(3);
    chk("bp_stable_id", 64'(out_id), 64'(hold_id));
    chk("bp_stable_delta", out_delta, hold_d);
    chk("bp_stable_start", out_start_ts, hold_s);
    ev(1, 20, 0, 0);
    out_ready = 1'b1;
    ev(0, 0, 1, 20);
    chk("bp_pushpop_no_drop", 64'(cnt_res_drop), 64'd1);
    idle(8);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Simultaneous start/end
    do_reset();
    ev(1, 2, 1, 2);
    chk("sim_miss", 64'(cnt_end_miss), 64'd1);
    chk("sim_slot0_vld", 64'(dut.slot_vld[0]), 64'd1);
    chk("sim_slot0_id", 64'(dut.slot_id[0]), 64'd2);
    idle(6);
    ev(0, 0, 1, 2);
    chk("sim_hit_id", 64'(out_id), 64'd2);
    chk("sim_hit_delta", out_delta, 64'd7);
    ev(1, 4, 0, 0);
    idle(2);
    ev(1, 4, 1, 4);
    chk("sim_realloc_id", 64'(out_id), 64'd4);
    chk("sim_realloc_delta", out_delta, 64'd3);
    ev(0, 0, 1, 4);
    chk("sim_second_delta", out_delta, 64'd1);
    chk("sim_miss_final", 64'(cnt_end_miss), 64'd1);

    // Reset mid-operation
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) ev(1, 30 + i, 0, 0);
    ev(0, 0, 1, 33);
    ev(0, 0, 1, 34);
    ev(0, 0, 1, 99);
    chk("mid_pre_miss", 64'(cnt_end_miss), 64'd1);
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0; ts_ofs = '0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_miss", 64'(cnt_end_miss), 64'd0);
    chk("mid_rst_ts", ts_now, 64'd0);
    ev(1, 40, 1, 30);
    chk("mid_ignored_valid", 64'(out_valid), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(4);
    out_ready = 1'b1;
    ev(0, 0, 1, 30);
    ev(0, 0, 1, 31);
    ev(0, 0, 1, 32);
    chk("mid_post_miss", 64'(cnt_end_miss), 64'd3);
    idle(2);
    chk("mid_post_valid", 64'(out_valid), 64'd0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      start_valid = ($urandom_range(0, 99) < 50);
      start_id    = ID_W'($urandom_range(0, 11));
      end_valid   = ($urandom_range(0, 99) < 50);
      end_id      = ID_W'($urandom_range(0, 11));
      out_ready   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    start_valid = 1'b0; end_valid = 1'b0; out_ready = 1'b1;
    idle(10);
    chk("rand_drained", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
